// File: rtl/noc_arb_pkg.sv
// noc_arb_pkg: shared types and constants for the NoC put-side arbiter.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

package noc_arb_pkg;

  // Arbiter FSM: one IDLE cycle per packet, then QUERY/CHECK/SEND per flit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUERY = 2'd1,
    CHECK = 2'd2,
    SEND  = 2'd3
  } arb_state_t;

  // Virtual channels offered by the router port
  localparam int NOC_NUM_VCS = 2;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search starting at ptr and wrapping past N_REQ-1.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W:0] cand;

  // Walk the candidates ptr, ptr+1, ... (mod N_REQ) and keep the first one requesting
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_put_arbiter.sv
// noc_put_arbiter: grants whole packets round-robin to local requesters and injects
// each flit into the router only after a fresh non-full VC query.
module noc_put_arbiter
  import noc_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int FLIT_W = `FLIT_WIDTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FLIT_W-1:0]  req_flit,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ-1:0]         req_vc,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     en_get_non_full_VCs,
  input  logic [NOC_NUM_VCS-1:0]   get_non_full_VCs,
  output logic [FLIT_W-1:0]        put_flit,
  output logic                     en_put,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             vc_q, vc_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic             last_q, last_d;
  logic             en_put_q, en_put_d;
  logic             en_get_q, en_get_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // Next-state logic; the strobes are precomputed so they leave the block as flops
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    vc_d      = vc_q;
    flit_d    = flit_q;
    last_d    = last_q;
    en_put_d  = 1'b0;
    en_get_d  = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d  = pick_idx;
          vc_d     = req_vc[pick_idx];
          state_d  = QUERY;
          en_get_d = 1'b1;
        end
      end
      QUERY: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (req_valid[grant_q] && get_non_full_VCs[vc_q]) begin
          req_ready[grant_q] = 1'b1;
          flit_d   = req_flit[int'(grant_q)*FLIT_W +: FLIT_W];
          last_d   = req_last[grant_q];
          state_d  = SEND;
          en_put_d = 1'b1;
        end else begin
          state_d  = QUERY;
          en_get_d = 1'b1;
        end
      end
      SEND: begin
        if (last_q) begin
          rr_ptr_d = (grant_q == IDX_W'(N_REQ-1)) ? '0 : grant_q + IDX_W'(1);
          state_d  = IDLE;
        end else begin
          state_d  = QUERY;
          en_get_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any flit acked but not yet put
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      vc_q     <= 1'b0;
      flit_q   <= '0;
      last_q   <= 1'b0;
      en_put_q <= 1'b0;
      en_get_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      vc_q     <= vc_d;
      flit_q   <= flit_d;
      last_q   <= last_d;
      en_put_q <= en_put_d;
      en_get_q <= en_get_d;
    end
  end

  assign put_flit            = flit_q;
  assign en_put              = en_put_q;
  assign en_get_non_full_VCs = en_get_q;
  assign grant_id            = grant_q;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_noc_put_arbiter.sv
// tb_noc_put_arbiter: directed scenarios against a packet/flit-level reference model.
module tb_noc_put_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int MAXF = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [N-1:0] req_valid, req_last, req_vc, req_ready;
  logic [N*W-1:0] req_flit;
  logic         en_get;
  logic [1:0]   nf;
  logic [W-1:0] put_flit;
  logic         en_put;
  logic [1:0]   grant_id;
  logic         busy;

  noc_put_arbiter #(.N_REQ(N), .FLIT_W(W)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .req_valid          (req_valid),
    .req_flit           (req_flit),
    .req_last           (req_last),
    .req_vc             (req_vc),
    .req_ready          (req_ready),
    .en_get_non_full_VCs(en_get),
    .get_non_full_VCs   (nf),
    .put_flit           (put_flit),
    .en_put             (en_put),
    .grant_id           (grant_id),
    .busy               (busy)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Requester packet memories (written only by the stimulus process)
  logic [W-1:0] pf [N][MAXF];
  logic         pl [N][MAXF];
  logic         pv [N][MAXF];
  int           plen [N];
  logic         hold [N];
  int           rw_req [N];
  int           rw_to [N];
  // Requester read pointers (written only by the driver process)
  int           pidx [N] = '{default: 0};
  int           rw_done [N] = '{default: 0};
  logic         acc [N] = '{default: 1'b0};

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Observation logs filled by the compare process
  int           put_n = 0;
  logic [W-1:0] put_dat [64];
  int           put_cyc [64];
  int           put_gid [64];
  int           gr_n = 0;
  int           gr_id [64];
  int           gr_cyc [64];
  int           rdy_cnt [N] = '{default: 0};
  int           get_cnt = 0;
  logic         busy_prev = 1'b0;

  // Reference model state
  logic         m_busy;
  int           m_owner, m_vc, m_phase, m_ptr;
  logic [W-1:0] m_flit;
  logic         m_last;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Append one packet of n flits (payload base+k) to requester id; body flits carry the opposite VC
  task automatic applyStimulus(input int id, input int n, input int vc, input logic [W-1:0] base);
    for (int k = 0; k < n; k++) begin
      pf[id][plen[id]+k] = base + W'(k);
      pl[id][plen[id]+k] = (k == n-1);
      pv[id][plen[id]+k] = (k == 0) ? vc[0] : ~vc[0];
    end
    plen[id] = plen[id] + n;
  endtask

  task automatic atPosedge();
    @(posedge clk);
    #2;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Wait (bounded) until every requester is drained and the arbiter is idle
  task automatic waitIdle(input int bound, input string name);
    logic done;
    done = 1'b0;
    for (int t = 0; t < bound && !done; t++) begin
      @(negedge clk);
      #1;
      done = !busy;
      for (int i = 0; i < N; i++) if (pidx[i] < plen[i]) done = 1'b0;
    end
    checkOutput(name, 64'(done), 64'd1);
  endtask

  // Offered flit of each requester comes from its packet memory
  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_vc    = '0;
    req_flit  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (pidx[i] < plen[i]) && !hold[i];
      req_last[i]        = pl[i][pidx[i] % MAXF];
      req_vc[i]          = pv[i][pidx[i] % MAXF];
      req_flit[i*W +: W] = pf[i][pidx[i] % MAXF];
    end
  end

  // Remember which requesters saw a ready pulse this cycle
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) acc[i] = req_ready[i];
  end

  // Requesters step to their next flit after an accepted one, or rewind on request
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (rw_req[i] != rw_done[i]) begin
        pidx[i]    = rw_to[i];
        rw_done[i] = rw_req[i];
      end else if (acc[i]) begin
        pidx[i] = pidx[i] + 1;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Reference model: a packet owner, which third of the per-flit 3-cycle slot we are in, and the RR start point
  always @(posedge clk or negedge resetn) begin : model_blk
    int   c;
    logic hit;
    if (!resetn) begin
      m_busy = 1'b0; m_owner = 0; m_vc = 0; m_phase = 0; m_ptr = 0; m_flit = '0; m_last = 1'b0;
    end else if (!m_busy) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!hit && req_valid[c]) begin
          hit = 1'b1; m_owner = c; m_vc = int'(req_vc[c]);
        end
      end
      if (hit) begin
        m_busy = 1'b1; m_phase = 0;
      end
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (req_valid[m_owner] && nf[m_vc]) begin
        m_flit = req_flit[m_owner*W +: W]; m_last = req_last[m_owner]; m_phase = 2;
      end else begin
        m_phase = 0;
      end
    end else begin
      if (m_last) begin
        m_ptr = (m_owner + 1) % N; m_busy = 1'b0;
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model, plus event logging
  always @(negedge clk) begin : compare_blk
    logic [N-1:0] exp_rdy;
    if (resetn) begin
      exp_rdy = '0;
      if (m_busy && m_phase == 1 && req_valid[m_owner] && nf[m_vc]) exp_rdy[m_owner] = 1'b1;
      checkOutput("req_ready", 64'(req_ready), 64'(exp_rdy));
      checkOutput("en_put", 64'(en_put), 64'(m_busy && m_phase == 2));
      checkOutput("en_get", 64'(en_get), 64'(m_busy && m_phase == 0));
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("grant_id", 64'(grant_id), 64'(m_owner));
      if (m_busy && m_phase == 2) checkOutput("put_flit", 64'(put_flit), 64'(m_flit));
      if (en_put && put_n < 64) begin
        put_dat[put_n] = put_flit; put_cyc[put_n] = cyc; put_gid[put_n] = int'(grant_id); put_n++;
      end
      if (en_get) get_cnt++;
      for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (busy && !busy_prev && gr_n < 64) begin
        gr_id[gr_n] = int'(grant_id); gr_cyc[gr_n] = cyc; gr_n++;
      end
      busy_prev = busy;
    end else begin
      busy_prev = 1'b0;
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios
  initial begin : stim
    int g0, p0, r0, gc0, st;
    nf = 2'b11;
    for (int i = 0; i < N; i++) begin
      plen[i] = 0; hold[i] = 1'b0; rw_req[i] = 0; rw_to[i] = 0;
      for (int k = 0; k < MAXF; k++) begin
        pf[i][k] = '0; pl[i][k] = 1'b0; pv[i][k] = 1'b0;
      end
    end
    #1 resetn = 1'b0;
    #2;
    checkOutput("rst_en_put", 64'(en_put), 64'd0);
    checkOutput("rst_put_flit", 64'(put_flit), 64'd0);
    checkOutput("rst_en_get", 64'(en_get), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    #19 resetn = 1'b1;

    // Scenario 1: requester 2 sends a 3-flit packet on VC1
    $display("[TB] scenario 1: single requester, 3-flit packet");
    g0 = gr_n; p0 = put_n; r0 = rdy_cnt[2];
    applyStimulus(2, 3, 1, 32'h200);
    waitIdle(60, "t1_done");
    checkOutput("t1_grant", 64'(gr_id[g0]), 64'd2);
    checkOutput("t1_put_count", 64'(put_n - p0), 64'd3);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_put_cycle", 64'(put_cyc[p0+k] - gr_cyc[g0]), 64'(2 + 3*k));
      checkOutput("t1_put_data", 64'(put_dat[p0+k]), 64'(32'h200 + k));
      checkOutput("t1_put_gid", 64'(put_gid[p0+k]), 64'd2);
    end
    checkOutput("t1_ready_count", 64'(rdy_cnt[2] - r0), 64'd3);
    checkOutput("t1_model_ptr", 64'(m_ptr), 64'd3);
    g0 = gr_n;
    applyStimulus(0, 1, 0, 32'h210);
    applyStimulus(3, 1, 0, 32'h230);
    waitIdle(40, "t1_rr_done");
    checkOutput("t1_rr_first", 64'(gr_id[g0]), 64'd3);
    checkOutput("t1_rr_second", 64'(gr_id[g0+1]), 64'd0);

    // Scenario 2: all four requesters busy from reset with single-flit packets
    $display("[TB] scenario 2: four requesters, round-robin from reset");
    #1 resetn = 1'b0;
    applyStimulus(0, 1, 0, 32'h300);
    applyStimulus(0, 1, 0, 32'h308);
    applyStimulus(1, 1, 1, 32'h310);
    applyStimulus(2, 1, 0, 32'h320);
    applyStimulus(3, 1, 1, 32'h330);
    g0 = gr_n; p0 = put_n;
    repeat (2) atPosedge();
    resetn = 1'b1;
    waitIdle(60, "t2_done");
    checkOutput("t2_grant0", 64'(gr_id[g0]), 64'd0);
    checkOutput("t2_grant1", 64'(gr_id[g0+1]), 64'd1);
    checkOutput("t2_grant2", 64'(gr_id[g0+2]), 64'd2);
    checkOutput("t2_grant3", 64'(gr_id[g0+3]), 64'd3);
    checkOutput("t2_grant4", 64'(gr_id[g0+4]), 64'd0);
    for (int k = 0; k < 4; k++) checkOutput("t2_spacing", 64'(gr_cyc[g0+k+1] - gr_cyc[g0+k]), 64'd4);
    checkOutput("t2_data0", 64'(put_dat[p0]), 64'h300);
    checkOutput("t2_data3", 64'(put_dat[p0+3]), 64'h330);
    checkOutput("t2_data4", 64'(put_dat[p0+4]), 64'h308);

    // Scenario 3: VC0 full for three queries while requester 0 waits
    $display("[TB] scenario 3: backpressure on VC0");
    nf = 2'b10;
    g0 = gr_n; p0 = put_n; r0 = rdy_cnt[1]; gc0 = get_cnt;
    applyStimulus(1, 1, 0, 32'h400);
    applyStimulus(0, 1, 0, 32'h410);
    for (int t = 0; t < 40 && get_cnt < gc0 + 4; t++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("t3_query_count", 64'(get_cnt - gc0), 64'd4);
    checkOutput("t3_no_ready", 64'(rdy_cnt[1] - r0), 64'd0);
    checkOutput("t3_no_put", 64'(put_n - p0), 64'd0);
    checkOutput("t3_one_grant", 64'(gr_n - g0), 64'd1);
    atPosedge();
    nf = 2'b11;
    waitIdle(40, "t3_done");
    checkOutput("t3_grant_first", 64'(gr_id[g0]), 64'd1);
    checkOutput("t3_grant_next", 64'(gr_id[g0+1]), 64'd0);
    checkOutput("t3_packet_len", 64'(gr_cyc[g0+1] - gr_cyc[g0]), 64'd10);
    checkOutput("t3_ready_count", 64'(rdy_cnt[1] - r0), 64'd1);
    checkOutput("t3_data", 64'(put_dat[p0]), 64'h400);

    // Scenario 4: VC chosen by the head stays in force for the body
    $display("[TB] scenario 4: VC locked on head flit");
    nf = 2'b11;
    p0 = put_n; r0 = rdy_cnt[0];
    applyStimulus(0, 2, 1, 32'h500);
    for (int t = 0; t < 40 && rdy_cnt[0] == r0; t++) begin
      @(negedge clk);
      #1;
    end
    atPosedge();
    nf = 2'b01;
    waitCycles(12);
    checkOutput("t4_body_stalled", 64'(rdy_cnt[0] - r0), 64'd1);
    checkOutput("t4_busy", 64'(busy), 64'd1);
    checkOutput("t4_grant", 64'(grant_id), 64'd0);
    checkOutput("t4_puts", 64'(put_n - p0), 64'd1);
    atPosedge();
    nf = 2'b11;
    waitIdle(40, "t4_done");
    checkOutput("t4_puts_final", 64'(put_n - p0), 64'd2);
    checkOutput("t4_body_data", 64'(put_dat[p0+1]), 64'h501);

    // Scenario 5: requester 3 withdraws its valid after the head
    $display("[TB] scenario 5: mid-packet withdrawal");
    p0 = put_n; r0 = rdy_cnt[3];
    applyStimulus(3, 2, 0, 32'h600);
    for (int t = 0; t < 40 && rdy_cnt[3] == r0; t++) begin
      @(negedge clk);
      #1;
    end
    atPosedge();
    hold[3] = 1'b1;
    waitCycles(1);
    gc0 = put_n;
    waitCycles(5);
    checkOutput("t5_grant", 64'(grant_id), 64'd3);
    checkOutput("t5_busy", 64'(busy), 64'd1);
    checkOutput("t5_no_put", 64'(put_n - gc0), 64'd0);
    atPosedge();
    hold[3] = 1'b0;
    waitIdle(40, "t5_done");
    checkOutput("t5_puts", 64'(put_n - p0), 64'd2);
    checkOutput("t5_body_data", 64'(put_dat[p0+1]), 64'h601);

    // Scenario 6: asynchronous reset while a flit is on the wire
    $display("[TB] scenario 6: reset during SEND");
    p0 = put_n;
    st = plen[2];
    applyStimulus(2, 2, 0, 32'h700);
    for (int t = 0; t < 40 && put_n == p0; t++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("t6_in_send", 64'(en_put), 64'd1);
    #1 resetn = 1'b0;
    #1;
    checkOutput("t6_rst_en_put", 64'(en_put), 64'd0);
    checkOutput("t6_rst_put_flit", 64'(put_flit), 64'd0);
    checkOutput("t6_rst_en_get", 64'(en_get), 64'd0);
    checkOutput("t6_rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("t6_rst_grant_id", 64'(grant_id), 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    rw_to[2] = st;
    rw_req[2] = rw_req[2] + 1;
    applyStimulus(0, 1, 0, 32'h710);
    g0 = gr_n; p0 = put_n;
    repeat (2) atPosedge();
    resetn = 1'b1;
    waitIdle(60, "t6_done");
    checkOutput("t6_first_grant", 64'(gr_id[g0]), 64'd0);
    checkOutput("t6_second_grant", 64'(gr_id[g0+1]), 64'd2);
    checkOutput("t6_data0", 64'(put_dat[p0]), 64'h710);
    checkOutput("t6_data1", 64'(put_dat[p0+1]), 64'h700);
    checkOutput("t6_data2", 64'(put_dat[p0+2]), 64'h701);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
